// File: rtl/track_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : track_arbiter
// Description : Shares the single-port track tile BRAM between the forward-view
//               video pipeline (absolute priority, never stalled) and the game
//               logic (valid/ready request, served only in video-idle cycles).
//               Optional macro TRACK_ARB_WRITE_EN enables the game write path;
//               without it every game request is a read and the RAM write port
//               is tied off.
// Revision    : 1.0 - initial release
// ============================================================================
module track_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              vid_active_in,
    input  logic [ADDR_W-1:0] vid_addr_in,
    output logic              vid_valid_out,
    output logic [DATA_W-1:0] vid_data_out,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic              req_we_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              rsp_valid_out,
    input  logic              rsp_ready_in,
    output logic [DATA_W-1:0] rsp_data_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic              ram_we_out,
    output logic [DATA_W-1:0] ram_din_out,
    input  logic [DATA_W-1:0] ram_dout_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_op_addr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [RD_LAT:0]   r_vid_tag;
    logic [RD_LAT:0]   r_game_tag;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_capture_data;

    logic              w_accept;
    logic              w_grant;
    logic              w_capture;
    logic              w_rsp_done;

    // Grant only when the video side leaves the port free this cycle.
    assign w_accept   = (r_state == ST_IDLE) && req_valid_in;
    assign w_grant    = (r_state == ST_PEND) && !vid_active_in;
    assign w_capture  = (r_state == ST_WAIT) && r_game_tag[RD_LAT];
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready_in;

    // Game-side state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Game-side next-state logic; PEND waits indefinitely for an idle video slot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_next = ST_PEND;
            ST_PEND: if (w_grant)    w_state_next = ST_WAIT;
            ST_WAIT: if (w_capture)  w_state_next = ST_RESP;
            ST_RESP: if (w_rsp_done) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Latch the request address at the handshake.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)       r_op_addr <= '0;
        else if (w_accept) r_op_addr <= req_addr_in;
    end

    // RAM address register: video first, game op on grant, otherwise hold.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)            r_ram_addr <= '0;
        else if (vid_active_in) r_ram_addr <= vid_addr_in;
        else if (w_grant)       r_ram_addr <= r_op_addr;
    end

    // Slot tags follow each RAM access through the read pipeline.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_vid_tag  <= '0;
            r_game_tag <= '0;
        end else begin
            r_vid_tag  <= {r_vid_tag[RD_LAT-1:0], vid_active_in};
            r_game_tag <= {r_game_tag[RD_LAT-1:0], w_grant};
        end
    end

`ifdef TRACK_ARB_WRITE_EN
    logic              r_op_we;
    logic [DATA_W-1:0] r_op_wdata;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_din;

    // Latch write attributes at the handshake.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_op_we    <= 1'b0;
            r_op_wdata <= '0;
        end else if (w_accept) begin
            r_op_we    <= req_we_in;
            r_op_wdata <= req_wdata_in;
        end
    end

    // Write strobe lives for the single granted slot only.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ram_we  <= 1'b0;
            r_ram_din <= '0;
        end else begin
            r_ram_we <= w_grant & r_op_we;
            if (w_grant) r_ram_din <= r_op_wdata;
        end
    end

    assign ram_we_out     = r_ram_we;
    assign ram_din_out    = r_ram_din;
    assign w_capture_data = r_op_we ? '0 : ram_dout_in;
`else
    logic w_unused_wr;
    assign w_unused_wr    = &{1'b0, req_we_in, req_wdata_in};
    assign ram_we_out     = 1'b0;
    assign ram_din_out    = '0;
    assign w_capture_data = ram_dout_in;
`endif

    // Response register: captured at the end of the read latency, cleared on handshake.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)         r_rsp_data <= '0;
        else if (w_capture)  r_rsp_data <= w_capture_data;
        else if (w_rsp_done) r_rsp_data <= '0;
    end

    assign ram_addr_out  = r_ram_addr;
    assign vid_valid_out = r_vid_tag[RD_LAT];
    assign vid_data_out  = r_vid_tag[RD_LAT] ? ram_dout_in : '0;
    assign rsp_valid_out = (r_state == ST_RESP);
    assign rsp_data_out  = r_rsp_data;
    // Ready is forced low while reset is held, high as soon as it is released.
    assign req_ready_out = (r_state == ST_IDLE) && rst_in;

endmodule
`default_nettype wire

// File: tb/tb_track_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_arbiter
// Description : Scoreboard bench for track_arbiter with a read-first BRAM model.
//               Build with TRACK_ARB_WRITE_EN to exercise the write path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_track_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 2;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              vid_active_in = 1'b0;
    logic [ADDR_W-1:0] vid_addr_in = '0;
    logic              vid_valid_out;
    logic [DATA_W-1:0] vid_data_out;
    logic              req_valid_in = 1'b0;
    logic              req_ready_out;
    logic [ADDR_W-1:0] req_addr_in = '0;
    logic              req_we_in = 1'b0;
    logic [DATA_W-1:0] req_wdata_in = '0;
    logic              rsp_valid_out;
    logic              rsp_ready_in = 1'b1;
    logic [DATA_W-1:0] rsp_data_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic              ram_we_out;
    logic [DATA_W-1:0] ram_din_out;
    logic [DATA_W-1:0] ram_dout_in;

    track_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .vid_active_in (vid_active_in),
        .vid_addr_in   (vid_addr_in),
        .vid_valid_out (vid_valid_out),
        .vid_data_out  (vid_data_out),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_addr_in   (req_addr_in),
        .req_we_in     (req_we_in),
        .req_wdata_in  (req_wdata_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_data_out  (rsp_data_out),
        .ram_addr_out  (ram_addr_out),
        .ram_we_out    (ram_we_out),
        .ram_din_out   (ram_din_out),
        .ram_dout_in   (ram_dout_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Read-first BRAM model, RD_LAT cycles from address to data.
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem[ram_addr_out];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_we_out) mem[ram_addr_out] = ram_din_out;
    end
    assign ram_dout_in = rd_pipe[RD_LAT-1];

    typedef struct {
        int              cyc;
        logic [DATA_W-1:0] data;
    } sb_t;

    sb_t vid_q[$];
    sb_t rsp_q[$];
    sb_t e_vid;
    sb_t e_rsp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops scoreboards on outputs and checks response hold/clear rules.
    int                we_cycles = 0;
    logic [ADDR_W-1:0] we_addr = '0;
    logic [DATA_W-1:0] we_din = '0;
    int                addr_hits = 0;
    logic              burst_win = 1'b0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clk_in) begin
        if (ram_we_out) begin
            we_cycles++;
            we_addr = ram_addr_out;
            we_din  = ram_din_out;
        end
        if (burst_win && ram_addr_out == 8'h33) addr_hits++;
        if (vid_valid_out) begin
            if (vid_q.size() == 0) check("vid_unexpected", 1, 0);
            else begin
                e_vid = vid_q.pop_front();
                check("vid_cycle", cyc, e_vid.cyc);
                check("vid_data", int'(vid_data_out), int'(e_vid.data));
            end
        end else if (vid_data_out != '0) begin
            check("vid_idle_data", int'(vid_data_out), 0);
        end
        if (rst_in && prev_valid && prev_ready)
            check("rsp_clear", int'(rsp_valid_out), 0);
        if (rst_in && prev_valid && !prev_ready) begin
            check("rsp_hold", int'(rsp_valid_out), 1);
            check("rsp_stable", int'(rsp_data_out), int'(prev_data));
        end
        if (rsp_valid_out && !prev_valid) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                e_rsp = rsp_q.pop_front();
                check("rsp_cycle", cyc, e_rsp.cyc);
                check("rsp_data", int'(rsp_data_out), int'(e_rsp.data));
            end
        end
        prev_valid = rsp_valid_out;
        prev_ready = rsp_ready_in;
        prev_data  = rsp_data_out;
    end

    task automatic drive_video(input logic [ADDR_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            vid_active_in = 1'b1;
            vid_addr_in   = base + ADDR_W'(i);
            vid_q.push_back('{cyc + 1 + RD_LAT, vid_addr_in[3:0]});
            @(posedge clk_in); #1;
        end
        vid_active_in = 1'b0;
    endtask

    // Issue one game request; rise_off < 0 means no response is expected.
    task automatic game_req(input logic [ADDR_W-1:0] a, input logic we,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_d,
                            input int rise_off);
        int n = 0;
        req_valid_in = 1'b1;
        req_addr_in  = a;
        req_we_in    = we;
        req_wdata_in = wd;
        @(negedge clk_in);
        while (!req_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("req_accept", int'(req_ready_out), 1);
        if (rise_off >= 0) rsp_q.push_back('{cyc + rise_off, exp_d});
        @(posedge clk_in); #1;
        req_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    logic [DATA_W-1:0] exp_rd;
    int                exp_we;
    int                n_wait;
    int                v0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i);
        mem[8'h5A] = 4'h7;

        // Reset then idle
        rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", int'(req_ready_out), 0);
        check("rst_vid_valid", int'(vid_valid_out), 0);
        check("rst_rsp_valid", int'(rsp_valid_out), 0);
        check("rst_rsp_data", int'(rsp_data_out), 0);
        check("rst_ram_addr", int'(ram_addr_out), 0);
        check("rst_ram_we", int'(ram_we_out), 0);
        check("rst_ram_din", int'(ram_din_out), 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_ready", int'(req_ready_out), 1);
        check("post_rst_we_pulses", we_cycles, 0);
        @(posedge clk_in); #1;

        // Video streaming 0x00..0x0F
        drive_video(8'h00, 16);
        repeat (5) @(posedge clk_in); #1;

        // Game read with idle video, response held 4 cycles without ready
        rsp_ready_in = 1'b0;
        game_req(8'h5A, 1'b0, 4'h0, 4'h7, 2 + 1 + RD_LAT);
        n_wait = 0;
        @(negedge clk_in);
        while (!rsp_valid_out && n_wait < 20) begin
            @(negedge clk_in);
            n_wait++;
        end
        check("rsp_rise_seen", int'(rsp_valid_out), 1);
        repeat (4) @(posedge clk_in); #1;
        rsp_ready_in = 1'b1;
        repeat (4) @(posedge clk_in); #1;

        // Contention: 20 video cycles, game read 0x33 issued two cycles in
        v0 = cyc;
        burst_win = 1'b1;
        fork
            drive_video(8'h80, 20);
            begin
                repeat (2) @(posedge clk_in); #1;
                // grant at v0+20, response at grant + 2 + RD_LAT, handshake at v0+2
                game_req(8'h33, 1'b0, 4'h0, 4'h3, 18 + 2 + RD_LAT);
            end
        join
        @(negedge clk_in);
        burst_win = 1'b0;
        check("contention_addr_hidden", addr_hits, 0);
        @(negedge clk_in);
        check("contention_grant_addr", int'(ram_addr_out), 8'h33);
        repeat (8) @(posedge clk_in); #1;

        // Write then read 0x10
        we_cycles = 0;
`ifdef TRACK_ARB_WRITE_EN
        exp_rd = 4'hC;
        exp_we = 1;
`else
        exp_rd = 4'h0;
        exp_we = 0;
`endif
        game_req(8'h10, 1'b1, 4'hC, 4'h0, 2 + 1 + RD_LAT);
        repeat (8) @(posedge clk_in); #1;
        game_req(8'h10, 1'b0, 4'h0, exp_rd, 2 + 1 + RD_LAT);
        repeat (8) @(posedge clk_in); #1;
        check("we_pulse_count", we_cycles, exp_we);
`ifdef TRACK_ARB_WRITE_EN
        check("we_addr", int'(we_addr), 8'h10);
        check("we_din", int'(we_din), 4'hC);
`endif

        // Reset while the read is in WAIT
        game_req(8'h5A, 1'b0, 4'h0, 4'h0, -1);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("midrst_ready", int'(req_ready_out), 0);
        check("midrst_rsp_valid", int'(rsp_valid_out), 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        check("midrst_no_rsp", int'(rsp_valid_out), 0);
        @(posedge clk_in); #1;
        game_req(8'h5A, 1'b0, 4'h0, 4'h7, 2 + 1 + RD_LAT);
        repeat (8) @(posedge clk_in); #1;

        check("vid_queue_drained", vid_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
